// File: rtl/clk_divn_multi.sv
// Multi-channel runtime-programmable integer clock divider, 50% duty for odd and even divisors.
// Optional macro CLKDIV_TICK_EN adds tick_out, a one-clk strobe at each period start.
module clk_divn_multi #(
  parameter int NCH         = 2,
  parameter int W           = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   en,
  input  logic [NCH-1:0]   div_load,
  input  logic [NCH*W-1:0] div_in,
  input  logic             sync,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH*W-1:0] div_active,
  output logic [NCH-1:0]   cfg_err
`ifdef CLKDIV_TICK_EN
  ,
  output logic [NCH-1:0]   tick_out
`endif
);

  // Handshake: div_load[i] and sync are single-cycle strobes sampled on posedge clk;
  // there is no ready, every strobe is accepted in the cycle it is seen.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // stopped, cnt held at 0, clk_out low
    ST_RUN   = 2'd1,  // counting 0..D-1
    ST_ALIGN = 2'd2   // one blank cycle after sync before the aligned restart
  } ch_state_e;

  localparam logic [W-1:0] DIV_MIN = W'(2);
  localparam logic [W-1:0] DIV_RST = W'(DEFAULT_DIV);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    ch_state_e    state;
    logic [W-1:0] cnt;
    logic [W-1:0] div_q;
    logic [W-1:0] pend;
    logic [W-1:0] ld_raw;
    logic [W-1:0] ld_div;
    logic [W-1:0] nxt_div;
    logic [W-1:0] half;
    logic         pend_v;
    logic         ld_bad;
    logic         wrap;
    logic         sync_hit;
    logic         clk_pos;
    logic         clk_odd;
    logic         clk_neg;
    logic         err_q;

    assign ld_raw   = div_in[i*W +: W];
    assign ld_bad   = (ld_raw < DIV_MIN);
    assign ld_div   = ld_bad ? DIV_MIN : ld_raw;
    // A strobe in the applying cycle beats an older pending value.
    assign nxt_div  = div_load[i] ? ld_div : (pend_v ? pend : div_q);
    assign half     = div_q >> 1;
    assign wrap     = (cnt == div_q - W'(1));
    assign sync_hit = sync & en[i];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state   <= ST_IDLE;
        cnt     <= '0;
        div_q   <= DIV_RST;
        pend    <= '0;
        pend_v  <= 1'b0;
        clk_pos <= 1'b0;
        clk_odd <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        // High for the first floor(D/2) counts; registered, so it trails cnt by one clk.
        clk_pos <= (state == ST_RUN) && (cnt < half);
        clk_odd <= div_q[0];
        if (div_load[i]) begin
          pend   <= ld_div;
          pend_v <= 1'b1;
          if (ld_bad) err_q <= 1'b1;
        end
        if (sync_hit) begin
          state   <= ST_ALIGN;
          cnt     <= '0;
          div_q   <= nxt_div;
          pend_v  <= 1'b0;
          clk_pos <= 1'b0;
        end else begin
          case (state)
            ST_ALIGN: state <= ST_RUN;
            ST_RUN: begin
              if (wrap) begin
                cnt    <= '0;
                div_q  <= nxt_div;
                pend_v <= 1'b0;
                if (!en[i]) state <= ST_IDLE;
              end else begin
                cnt <= cnt + W'(1);
              end
            end
            ST_IDLE: begin
              if (en[i]) begin
                state  <= ST_RUN;
                cnt    <= '0;
                div_q  <= nxt_div;
                pend_v <= 1'b0;
              end
            end
            default: state <= ST_IDLE;
          endcase
        end
      end
    end

    // Half-clk extension of the high phase; only odd divisors use it.
    always_ff @(negedge clk or negedge reset) begin
      if (!reset) clk_neg <= 1'b0;
      else        clk_neg <= clk_pos & clk_odd;
    end

`ifdef CLKDIV_TICK_EN
    logic tick_q;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) tick_q <= 1'b0;
      else tick_q <= !sync_hit && ((state == ST_ALIGN) ||
                                   (state == ST_RUN && wrap && en[i]) ||
                                   (state == ST_IDLE && en[i]));
    end
    assign tick_out[i] = tick_q;
`endif

    assign clk_out[i]          = clk_pos | clk_neg;
    assign div_active[i*W +: W] = div_q;
    assign cfg_err[i]          = err_q;
  end

endmodule
